// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter with a one-word holding buffer so that
// consecutive words stream out without an idle cycle between them.
module piso_serializer #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic             shift_en,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             ser_last,
   output logic             busy
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state, state_d;
   logic [WIDTH-1:0] sreg, sreg_d;
   logic [WIDTH-1:0] hold, hold_d;
   logic             hold_full, hold_full_d;
   logic [CW-1:0]    cnt, cnt_d;
   logic [WIDTH-1:0] sreg_shifted;

   // Move one place toward the output end, zero fill behind.
   assign sreg_shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0}
                                   : {1'b0, sreg[WIDTH-1:1]};

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state     <= IDLE;
         sreg      <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
         cnt       <= '0;
      end else begin
         state     <= state_d;
         sreg      <= sreg_d;
         hold      <= hold_d;
         hold_full <= hold_full_d;
         cnt       <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state;
      sreg_d      = sreg;
      hold_d      = hold;
      hold_full_d = hold_full;
      cnt_d       = cnt;
      load_ready  = !hold_full;
      ser_valid   = 1'b0;
      ser_out     = 1'b0;
      ser_last    = 1'b0;

      case (state)
         IDLE: begin
            if (hold_full) begin
               sreg_d      = hold;
               hold_full_d = 1'b0;
               cnt_d       = '0;
               state_d     = SHIFT;
            end
         end
         SHIFT: begin
            ser_valid = 1'b1;
            ser_out   = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
            ser_last  = (cnt == CNT_LAST);
            if (shift_en) begin
               if (cnt != CNT_LAST) begin
                  sreg_d = sreg_shifted;
                  cnt_d  = cnt + CW'(1);
               end else if (hold_full) begin
                  sreg_d      = hold;
                  hold_full_d = 1'b0;
                  cnt_d       = '0;
               end else begin
                  sreg_d  = '0;
                  cnt_d   = '0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // An accept never coincides with a hold-to-sreg transfer: one needs
      // hold_full low, the other needs it high.
      if (load_valid && !hold_full) begin
         hold_d      = load_data;
         hold_full_d = 1'b1;
      end

      busy = ser_valid || hold_full;
   end

endmodule
